// File: rtl/bram_rsp.sv
// bram_rsp: bank-side read responder for one activation/weight buffer lane.
// Reads take priority over the byte-masked loader write port and return
// in request order through a fixed two-cycle pipeline.
module bram_rsp #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DEPTH  = 32768,
    parameter int unsigned DW     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bce,
    input  logic [ADDR_W-1:0] braddr,
    output logic [DW-1:0]     brdata,
    output logic              brvalid,
    output logic              brerr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [DW/8-1:0]   wr_mask
);

    localparam int unsigned BW    = DW / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];

    logic             rd_oob_c;
    logic             wr_en_c;

    logic             s1_valid_q;
    logic             s1_oob_q;
    logic [IDX_W-1:0] s1_addr_q;

    logic             s2_valid_q;
    logic             s2_oob_q;
    logic [DW-1:0]    s2_data_q;

    logic [DW-1:0]    brdata_q, brdata_d;
    logic             brvalid_q, brvalid_d;
    logic             brerr_q, brerr_d;

    // The requester cannot be stalled, so any read cycle blocks the write port
    assign wr_ready = ~bce;
    assign rd_oob_c = ({1'b0, braddr} >= DEPTH_W);
    assign wr_en_c  = wr_valid & ~bce & ({1'b0, wr_addr} < DEPTH_W);

    // Byte-masked array write; out-of-range writes are silently dropped
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (wr_mask[b]) begin
                    mem_q[IDX_W'(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // S1: capture request valid, word index and range flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_oob_q   <= 1'b0;
            s1_addr_q  <= '0;
        end else begin
            s1_valid_q <= bce;
            s1_oob_q   <= bce & rd_oob_c;
            if (bce) begin
                s1_addr_q <= IDX_W'(braddr);
            end
        end
    end

    // Array read register, loaded only for live requests
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            s2_data_q <= mem_q[s1_addr_q];
        end
    end

    // S2 control: carry valid and range flag alongside the read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_oob_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_oob_q   <= s1_oob_q;
        end
    end

    // Response formatting: zero data on out-of-range, hold data when idle
    always_comb begin
        brdata_d  = brdata_q;
        brvalid_d = s2_valid_q;
        brerr_d   = 1'b0;
        if (s2_valid_q) begin
            brdata_d = s2_oob_q ? '0 : s2_data_q;
            brerr_d  = s2_oob_q;
        end
    end

    // Registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brdata_q  <= '0;
            brvalid_q <= 1'b0;
            brerr_q   <= 1'b0;
        end else begin
            brdata_q  <= brdata_d;
            brvalid_q <= brvalid_d;
            brerr_q   <= brerr_d;
        end
    end

    assign brdata  = brdata_q;
    assign brvalid = brvalid_q;
    assign brerr   = brerr_q;

endmodule

// File: tb/tb_bram_rsp.sv
// Bench for bram_rsp: reference model of the bank plus per-cycle response checks.
module tb_bram_rsp;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned DW     = 64;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b1;
    logic              bce      = 1'b0;
    logic [ADDR_W-1:0] braddr   = '0;
    logic [DW-1:0]     brdata;
    logic              brvalid;
    logic              brerr;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr  = '0;
    logic [DW-1:0]     wr_data  = '0;
    logic [DW/8-1:0]   wr_mask  = '0;

    bram_rsp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bce      (bce),
        .braddr   (braddr),
        .brdata   (brdata),
        .brvalid  (brvalid),
        .brerr    (brerr),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] data;
        bit          err;
        bit          known;
    } exp_t;

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    int          cyc       = 0;
    int          wr_count  = 0;
    exp_t        exp_q [$];
    logic [63:0] mm [int];
    logic [63:0] last_data  = '0;
    bit          last_known = 1'b1;

    logic [63:0] log_d [$];
    bit          log_e [$];
    int          log_c [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: bank contents and the response each accepted read must produce
    always @(posedge clk) begin
        exp_t        e;
        int          a;
        logic [63:0] w;
        cyc = cyc + 1;
        if (rst_n && bce) begin
            a       = int'(braddr);
            e.due   = cyc + 2;
            e.err   = (a >= int'(DEPTH));
            e.known = 1'b1;
            e.data  = '0;
            if (!e.err) begin
                if (mm.exists(a)) e.data = mm[a];
                else e.known = 1'b0;
            end
            exp_q.push_back(e);
        end
        if (wr_valid && !bce) begin
            wr_count++;
            a = int'(wr_addr);
            if (a < int'(DEPTH) && (mm.exists(a) || wr_mask == 8'hFF)) begin
                w = mm.exists(a) ? mm[a] : 64'h0;
                for (int b = 0; b < 8; b++)
                    if (wr_mask[b]) w[8*b +: 8] = wr_data[8*b +: 8];
                mm[a] = w;
            end
        end
    end

    // Reset discards all in-flight responses and zeroes the data output
    always @(negedge rst_n) begin
        exp_q.delete();
        last_data  = '0;
        last_known = 1'b1;
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        exp_t e;
        chk("wr_ready", 64'(wr_ready), 64'(!bce));
        if (brvalid === 1'b1) begin
            log_d.push_back(brdata);
            log_e.push_back(brerr);
            log_c.push_back(cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("brvalid_resp", 64'(brvalid), 64'(1));
            chk("brerr_resp", 64'(brerr), 64'(e.err));
            if (e.known) chk("brdata_resp", brdata, e.data);
            last_data  = e.data;
            last_known = e.known;
        end else begin
            chk("brvalid_idle", 64'(brvalid), 64'(0));
            chk("brerr_idle", 64'(brerr), 64'(0));
            if (last_known) chk("brdata_hold", brdata, last_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        log_d.delete();
        log_e.delete();
        log_c.delete();
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic [7:0] m);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(a);
        wr_data  = d;
        wr_mask  = m;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input int a);
        bce    = 1'b1;
        braddr = ADDR_W'(a);
        step();
        bce    = 1'b0;
    endtask

    initial begin
        logic        rdy [4];
        int          k;
        int          wc;
        logic [63:0] v;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_brvalid", 64'(brvalid), 64'(0));
        chk("rst_brerr", 64'(brerr), 64'(0));
        chk("rst_brdata", brdata, 64'h0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Fill then stream
        for (int i = 0; i < 8; i++) wr(i, 64'h1111_0000_0000_0000 + 64'(i), 8'hFF);
        clr();
        bce = 1'b1;
        k   = cyc;
        for (int i = 0; i < 8; i++) begin
            braddr = ADDR_W'(i);
            step();
        end
        bce = 1'b0;
        repeat (4) step();
        chk("stream_count", 64'(log_d.size()), 64'(8));
        if (log_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                v = 64'h1111_0000_0000_0000 + 64'(i);
                chk("stream_data", log_d[i], v);
                chk("stream_cycle", 64'(log_c[i]), 64'(k + 3 + i));
            end
        end

        // Byte mask
        wr(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(5, 64'h0000_0000_0000_00AB, 8'h01);
        clr();
        rd(5);
        repeat (3) step();
        chk("mask_count", 64'(log_d.size()), 64'(1));
        if (log_d.size() > 0) chk("mask_data", log_d[0], 64'hFFFF_FFFF_FFFF_FFAB);

        // Read priority over a held write request
        clr();
        wc       = wr_count;
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(20);
        wr_data  = 64'h55;
        wr_mask  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            bce    = (i != 2);
            braddr = ADDR_W'(i);
            #1 rdy[i] = wr_ready;
            step();
        end
        wr_valid = 1'b0;
        bce      = 1'b0;
        repeat (4) step();
        chk("prio_rdy0", 64'(rdy[0]), 64'(0));
        chk("prio_rdy1", 64'(rdy[1]), 64'(0));
        chk("prio_rdy2", 64'(rdy[2]), 64'(1));
        chk("prio_rdy3", 64'(rdy[3]), 64'(0));
        chk("prio_writes", 64'(wr_count - wc), 64'(1));
        chk("prio_resps", 64'(log_d.size()), 64'(3));
        clr();
        rd(20);
        repeat (3) step();
        if (log_d.size() > 0) chk("prio_wdata", log_d[0], 64'h55);
        else chk("prio_wdata_count", 64'(log_d.size()), 64'(1));

        // Write at edge k, read at edge k+1
        clr();
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(9);
        wr_data  = 64'hDEAD;
        wr_mask  = 8'hFF;
        step();
        k        = cyc;
        wr_valid = 1'b0;
        rd(9);
        repeat (4) step();
        chk("wtr_count", 64'(log_d.size()), 64'(1));
        if (log_d.size() > 0) begin
            chk("wtr_data", log_d[0], 64'hDEAD);
            chk("wtr_cycle", 64'(log_c[0]), 64'(k + 3));
        end

        // Out-of-range sandwiched between in-range reads
        wr(1023, 64'h3FF, 8'hFF);
        wr(1030, 64'h77, 8'hFF);
        clr();
        bce = 1'b1;
        braddr = ADDR_W'(1023); step();
        braddr = ADDR_W'(1024); step();
        braddr = ADDR_W'(1023); step();
        bce = 1'b0;
        repeat (4) step();
        chk("oob_count", 64'(log_d.size()), 64'(3));
        if (log_d.size() == 3) begin
            chk("oob_data0", log_d[0], 64'h3FF);
            chk("oob_err0", 64'(log_e[0]), 64'(0));
            chk("oob_data1", log_d[1], 64'h0);
            chk("oob_err1", 64'(log_e[1]), 64'(1));
            chk("oob_data2", log_d[2], 64'h3FF);
            chk("oob_err2", 64'(log_e[2]), 64'(0));
            chk("oob_cycle", 64'(log_c[2] - log_c[0]), 64'(2));
        end

        // Reset pulse with two reads in flight
        clr();
        bce = 1'b1;
        braddr = ADDR_W'(0); step();
        braddr = ADDR_W'(1); step();
        bce = 1'b0;
        #1 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        repeat (5) step();
        chk("rst_no_resp", 64'(log_d.size()), 64'(0));
        rd(2);
        repeat (3) step();
        chk("rst_after_count", 64'(log_d.size()), 64'(1));
        if (log_d.size() > 0) chk("rst_retained", log_d[0], 64'h1111_0000_0000_0002);

        chk("pending_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
